// File: rtl/stream_maxmin_reduce.sv
// Streaming max/min reduction: finds the extreme operand of each packet, its first
// beat index and the beat count, and presents them with a valid/ready handshake.
module stream_maxmin_reduce #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode_min,
    input  logic             mode_signed,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_index,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;
    logic               r_mode_min;
    logic               r_mode_signed;

    logic               w_beat;
    logic               w_take;
    logic               w_first;
    logic               w_next;
    logic               w_cnt_sat;
    logic               w_wins;
    logic [WIDTH-1:0]   w_flip;
    logic [WIDTH-1:0]   w_cmp_in;
    logic [WIDTH-1:0]   w_cmp_acc;
    logic [CNT_W-1:0]   w_beat_idx;

    // Signed compare is done as unsigned with both MSBs inverted.
    always_comb begin
        w_flip     = {r_mode_signed, {(WIDTH-1){1'b0}}};
        w_cmp_in   = in_data ^ w_flip;
        w_cmp_acc  = r_acc ^ w_flip;
        w_wins     = r_mode_min ? (w_cmp_in < w_cmp_acc) : (w_cmp_in > w_cmp_acc);
        w_cnt_sat  = (r_cnt == CNT_MAX);
        w_beat_idx = w_cnt_sat ? CNT_MAX : r_cnt + CNT_W'(1);
    end

    // Next-state logic and handshake decode.
    always_comb begin
        w_state_nxt = r_state;
        w_beat      = in_valid && r_in_ready;
        w_take      = r_out_valid && out_ready;
        w_first     = 1'b0;
        w_next      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_beat) begin
                    w_first     = 1'b1;
                    w_state_nxt = in_last ? ST_HOLD : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (w_beat) begin
                    w_next = 1'b1;
                    if (in_last) begin
                        w_state_nxt = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (w_take) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register; handshake flags are registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt != ST_HOLD);
            r_out_valid <= (w_state_nxt == ST_HOLD);
        end
    end

    // Accumulator, winner index, saturating beat counter and overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc         <= '0;
            r_idx         <= '0;
            r_cnt         <= '0;
            r_ovf         <= 1'b0;
            r_mode_min    <= 1'b0;
            r_mode_signed <= 1'b0;
        end else if (w_first) begin
            r_acc         <= in_data;
            r_idx         <= '0;
            r_cnt         <= '0;
            r_ovf         <= 1'b0;
            r_mode_min    <= mode_min;
            r_mode_signed <= mode_signed;
        end else if (w_next) begin
            if (w_cnt_sat) begin
                r_ovf <= 1'b1;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            // Strict compare keeps the earliest beat on ties.
            if (w_wins) begin
                r_acc <= in_data;
                r_idx <= w_beat_idx;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_acc;
    assign out_index = r_idx;
    assign out_count = r_cnt;
    assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_stream_maxmin_reduce.sv
// Directed bench for stream_maxmin_reduce: a default instance plus a CNT_W=2
// instance sharing the same stimulus to exercise counter saturation.
module tb_stream_maxmin_reduce;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode_min;
    logic        mode_signed;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [7:0]  out_index;
    logic [7:0]  out_count;
    logic        out_ovf;

    logic        o2_in_ready;
    logic        o2_out_valid;
    logic [31:0] o2_data;
    logic [1:0]  o2_index;
    logic [1:0]  o2_count;
    logic        o2_ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stream_maxmin_reduce #(.WIDTH(32), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .mode_min(mode_min), .mode_signed(mode_signed),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_count(out_count), .out_ovf(out_ovf)
    );

    stream_maxmin_reduce #(.WIDTH(32), .CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .mode_min(mode_min), .mode_signed(mode_signed),
        .in_valid(in_valid), .in_ready(o2_in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(o2_out_valid), .out_ready(out_ready), .out_data(o2_data),
        .out_index(o2_index), .out_count(o2_count), .out_ovf(o2_ovf)
    );

    // Presents one beat for one clock edge, then idles the input.
    task automatic beat(input logic [31:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", out_data); end
        checks++; if (out_index !== 8'h0) begin errors++; $display("FAIL reset_index: got %0d want 0", out_index); end
        checks++; if (out_count !== 8'h0) begin errors++; $display("FAIL reset_count: got %0d want 0", out_count); end
        checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", out_ovf); end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_unsigned_max();
        mode_min = 1'b0; mode_signed = 1'b0;
        beat(32'd5, 1'b0);
        beat(32'hFFFF_FFFF, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL umax_early_valid: got %b want 0", out_valid); end
        beat(32'd7, 1'b1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL umax_valid: got %b want 1", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL umax_in_ready: got %b want 0", in_ready); end
        checks++; if (out_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL umax_data: got %h want ffffffff", out_data); end
        checks++; if (out_index !== 8'd1) begin errors++; $display("FAIL umax_index: got %0d want 1", out_index); end
        checks++; if (out_count !== 8'd2) begin errors++; $display("FAIL umax_count: got %0d want 2", out_count); end
        consume();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL umax_taken_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL umax_taken_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_signed_min();
        // Modes flip after the first beat and must be ignored for the rest of the packet.
        mode_min = 1'b1; mode_signed = 1'b1;
        beat(32'd3, 1'b0);
        mode_min = 1'b0; mode_signed = 1'b0;
        beat(32'h8000_0000, 1'b0);
        beat(32'h7FFF_FFFF, 1'b1);
        checks++; if (out_data !== 32'h8000_0000) begin errors++; $display("FAIL smin_data: got %h want 80000000", out_data); end
        checks++; if (out_index !== 8'd1) begin errors++; $display("FAIL smin_index: got %0d want 1", out_index); end
        consume();
        mode_min = 1'b1; mode_signed = 1'b0;
        beat(32'd3, 1'b0);
        mode_signed = 1'b1;
        beat(32'h8000_0000, 1'b0);
        beat(32'h7FFF_FFFF, 1'b1);
        checks++; if (out_data !== 32'd3) begin errors++; $display("FAIL umin_data: got %h want 3", out_data); end
        checks++; if (out_index !== 8'd0) begin errors++; $display("FAIL umin_index: got %0d want 0", out_index); end
        consume();
    endtask

    task automatic test_ties();
        // out_ready held high while accumulating must not disturb the packet.
        mode_min = 1'b0; mode_signed = 1'b0;
        out_ready = 1'b1;
        beat(32'd9, 1'b0);
        beat(32'd4, 1'b0);
        beat(32'd9, 1'b0);
        beat(32'd9, 1'b1);
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL tie_max_valid: got %b want 1", out_valid); end
        checks++; if (out_data !== 32'd9) begin errors++; $display("FAIL tie_max_data: got %h want 9", out_data); end
        checks++; if (out_index !== 8'd0) begin errors++; $display("FAIL tie_max_index: got %0d want 0", out_index); end
        checks++; if (out_count !== 8'd3) begin errors++; $display("FAIL tie_max_count: got %0d want 3", out_count); end
        consume();
        mode_min = 1'b1;
        beat(32'd4, 1'b0);
        beat(32'd2, 1'b0);
        beat(32'd2, 1'b1);
        checks++; if (out_data !== 32'd2) begin errors++; $display("FAIL tie_min_data: got %h want 2", out_data); end
        checks++; if (out_index !== 8'd1) begin errors++; $display("FAIL tie_min_index: got %0d want 1", out_index); end
        consume();
    endtask

    task automatic test_hold_stall();
        mode_min = 1'b0; mode_signed = 1'b0;
        out_ready = 1'b0;
        beat(32'h0000_ABCD, 1'b1);
        // Inputs presented during HOLD must be ignored.
        in_valid = 1'b1; in_data = 32'h1234_5678; in_last = 1'b1; mode_min = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b want 1", i, out_valid); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d]: got %b want 0", i, in_ready); end
            checks++; if (out_data !== 32'h0000_ABCD) begin errors++; $display("FAIL stall_data[%0d]: got %h want 0000abcd", i, out_data); end
            checks++; if (out_count !== 8'd0) begin errors++; $display("FAIL stall_count[%0d]: got %0d want 0", i, out_count); end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; mode_min = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_taken_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_taken_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_no_extra: got %b want 0", out_valid); end
        checks++; if (out_data !== 32'h0000_ABCD) begin errors++; $display("FAIL stall_no_accept: got %h want 0000abcd", out_data); end
    endtask

    task automatic test_overflow();
        mode_min = 1'b0; mode_signed = 1'b0;
        beat(32'd1, 1'b0);
        beat(32'd2, 1'b0);
        beat(32'd3, 1'b0);
        beat(32'd4, 1'b0);
        beat(32'd5, 1'b0);
        beat(32'h50, 1'b1);
        checks++; if (o2_out_valid !== 1'b1) begin errors++; $display("FAIL ovf_small_valid: got %b want 1", o2_out_valid); end
        checks++; if (o2_data !== 32'h50) begin errors++; $display("FAIL ovf_small_data: got %h want 50", o2_data); end
        checks++; if (o2_count !== 2'd3) begin errors++; $display("FAIL ovf_small_count: got %0d want 3", o2_count); end
        checks++; if (o2_index !== 2'd3) begin errors++; $display("FAIL ovf_small_index: got %0d want 3", o2_index); end
        checks++; if (o2_ovf !== 1'b1) begin errors++; $display("FAIL ovf_small_flag: got %b want 1", o2_ovf); end
        checks++; if (out_count !== 8'd5) begin errors++; $display("FAIL ovf_wide_count: got %0d want 5", out_count); end
        checks++; if (out_index !== 8'd5) begin errors++; $display("FAIL ovf_wide_index: got %0d want 5", out_index); end
        checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL ovf_wide_flag: got %b want 0", out_ovf); end
        consume();
        beat(32'd8, 1'b1);
        checks++; if (o2_ovf !== 1'b0) begin errors++; $display("FAIL ovf_cleared: got %b want 0", o2_ovf); end
        checks++; if (o2_count !== 2'd0) begin errors++; $display("FAIL ovf_next_count: got %0d want 0", o2_count); end
        consume();
    endtask

    task automatic test_reset_mid();
        mode_min = 1'b0; mode_signed = 1'b0;
        beat(32'h99, 1'b0);
        beat(32'h77, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", in_ready); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rstmid_acc: got %h want 0", out_data); end
        beat(32'h10, 1'b1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_new_valid: got %b want 1", out_valid); end
        checks++; if (out_data !== 32'h10) begin errors++; $display("FAIL rstmid_data: got %h want 10", out_data); end
        checks++; if (out_index !== 8'd0) begin errors++; $display("FAIL rstmid_index: got %0d want 0", out_index); end
        checks++; if (out_count !== 8'd0) begin errors++; $display("FAIL rstmid_count: got %0d want 0", out_count); end
        checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL rstmid_ovf: got %b want 0", out_ovf); end
        consume();
    endtask

    initial begin
        rst = 1'b1; mode_min = 1'b0; mode_signed = 1'b0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        test_reset();
        test_unsigned_max();
        test_signed_min();
        test_ties();
        test_hold_stall();
        test_overflow();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/stream_maxmin_reduce.md
STREAM_MAXMIN_REDUCE -- requirements
Module: stream_maxmin_reduce

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits (WIDTH >= 2).
REQ-002 Parameter CNT_W, default 8, width of the beat index and beat count.
REQ-003 Port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1, synchronous active-high reset.
REQ-005 Port mode_min, input, 1: 0 selects max reduction, 1 selects min reduction; sampled only on the first beat of a packet.
REQ-006 Port mode_signed, input, 1: 0 selects unsigned compare, 1 selects two's-complement compare; sampled only on the first beat of a packet.
REQ-007 Port in_valid, input, 1, input beat valid.
REQ-008 Port in_ready, output, 1, block accepts an input beat.
REQ-009 Port in_data, input, WIDTH, operand.
REQ-010 Port in_last, input, 1, marks the final beat of a packet.
REQ-011 Port out_valid, output, 1, result valid.
REQ-012 Port out_ready, input, 1, downstream accepts the result.
REQ-013 Port out_data, output, WIDTH, winning operand.
REQ-014 Port out_index, output, CNT_W, zero-based beat index of the winner.
REQ-015 Port out_count, output, CNT_W, number of beats in the packet minus one.
REQ-016 Port out_ovf, output, 1, packet exceeded 2^CNT_W beats.

Function
REQ-017 A beat SHALL be accepted when in_valid and in_ready are both 1 on the same rising edge; a result SHALL be taken when out_valid and out_ready are both 1.
REQ-018 The FSM SHALL have three states. IDLE: no packet open. ACCUM: packet open. HOLD: result presented.
REQ-019 in_ready SHALL be 1 in IDLE and ACCUM and 0 in HOLD; out_valid SHALL be 1 only in HOLD.
REQ-020 A beat accepted in IDLE SHALL load the accumulator with in_data, set the winner index to 0 and the beat counter to 0, and latch mode_min and mode_signed.
REQ-021 On that first beat, the FSM SHALL go to HOLD if in_last=1 and to ACCUM otherwise.
REQ-022 A beat accepted in ACCUM SHALL increment the beat counter.
REQ-023 On each ACCUM beat, the accumulator and the winner index SHALL be replaced only when in_data strictly beats the accumulator under the latched modes; the state SHALL go to HOLD when in_last=1.
REQ-024 Ties SHALL keep the earlier beat, so out_index is always the first occurrence of the extreme value.
REQ-025 "Strictly beats" SHALL mean in_data > acc for max and in_data < acc for min; signed mode compares as two's complement, which is equivalent to inverting the MSB of both operands and comparing unsigned.
REQ-026 The result SHALL appear in HOLD on the cycle after the last beat is accepted (latency 1 cycle).
REQ-027 In HOLD, out_data, out_index, out_count and out_ovf SHALL be held stable until the handshake completes.
REQ-028 On a completed result handshake the FSM SHALL return to IDLE; in_ready rises on the following cycle, so no beat is accepted in the cycle the result is taken.
REQ-029 The beat counter SHALL saturate at 2^CNT_W-1.
REQ-030 out_ovf SHALL be set when a beat arrives while the counter is already saturated, and cleared on the next first beat.
REQ-031 After saturation, winner updates SHALL continue, with the winner index saturating at 2^CNT_W-1.
REQ-032 In HOLD, in_valid, in_data, in_last and mode inputs SHALL be ignored.
REQ-033 In IDLE and ACCUM, out_ready SHALL be ignored.
REQ-034 Changes to mode_min or mode_signed mid-packet SHALL have no effect.

Reset
REQ-035 While rst=1 at a rising edge, the FSM SHALL enter IDLE and all of the following SHALL be 0: accumulator, index, counter, latched modes, out_ovf.
REQ-036 During and after reset, in_ready SHALL be 1 and out_valid SHALL be 0 from the first cycle after the reset edge.
REQ-037 A reset asserted in ACCUM or HOLD SHALL abandon the partial or pending result without emitting it.

Verification
REQ-038 Unsigned max (WIDTH=32), beats 5, 0xFFFFFFFF, 7 with last on the third beat -> out_data=0xFFFFFFFF, out_index=1, out_count=2, out_valid asserted 1 cycle after the last beat.
REQ-039 Signed min, beats 3, 0x80000000, 0x7FFFFFFF -> out_data=0x80000000, out_index=1; the same packet in unsigned min mode -> out_data=3, out_index=0.
REQ-040 Tie handling, max mode, beats 9, 4, 9, 9 -> out_index=0; min mode, beats 4, 2, 2 -> out_index=1.
REQ-041 Single-beat packet (in_last on the first beat) with out_ready held 0 for 5 cycles -> out_valid stays 1 with stable outputs and in_ready=0 throughout; result taken on the 6th cycle, then IDLE.
REQ-042 CNT_W=2, 6-beat max packet with the maximum on beat 5 -> out_count=3, out_ovf=1, out_index=3.
REQ-043 rst pulsed mid-packet after 2 beats, then a new 1-beat packet of value 0x10 -> out_data=0x10, out_index=0, out_ovf=0, and no stale result emitted.
